iomem_dma: RTL and testbench
============================

IOMEM_DMA -- requirements
Module: iomem_dma

Interface
REQ-001 SHALL have parameter LEN_W, default 16, transfer length width in 32-bit words.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256, stall limit per bus transaction (used only when IOMEM_DMA_TIMEOUT_EN is defined).
REQ-003 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports cmd_valid in 1 / cmd_ready out 1: command handshake; transfer happens when both are high on a clock edge.
REQ-006 SHALL have ports cmd_src in 32, cmd_dst in 32: byte addresses, word aligned (bits [1:0] ignored, driven 0 on bus).
REQ-007 SHALL have ports cmd_len in LEN_W (word count) and cmd_dst_fixed in 1 (1 = destination address not incremented).
REQ-008 SHALL have ports busy out 1, done out 1 (one-cycle pulse), err out 1 (one-cycle pulse, coincident with done).
REQ-009 SHALL have initiator ports iomem_valid out 1, iomem_ready in 1, iomem_wstrb out 4, iomem_addr out 32, iomem_wdata out 32, iomem_rdata in 32.

Function
REQ-010 SHALL implement FSM states IDLE, RD, RD_GAP, WR, WR_GAP, FIN.
REQ-011 SHALL assert cmd_ready only in IDLE; busy SHALL be high in every state except IDLE.
REQ-012 SHALL latch src, dst, len and fixed on command acceptance and ignore cmd_* inputs while busy.
REQ-013 SHALL, for len = 0, go IDLE -> FIN with no bus traffic and pulse done one cycle after acceptance.
REQ-014 SHALL, in RD, drive iomem_valid = 1, iomem_wstrb = 4'h0, iomem_addr = current src.
REQ-015 SHALL, in WR, drive iomem_valid = 1, iomem_wstrb = 4'hF, iomem_addr = current dst, iomem_wdata = last captured read data.
REQ-016 SHALL hold addr, wdata and wstrb stable while iomem_valid is high and iomem_ready is low.
REQ-017 SHALL capture iomem_rdata on the edge where RD and iomem_ready are both high, then enter RD_GAP.
REQ-018 SHALL, on the edge where WR and iomem_ready are both high, decrement the remaining count, add 4 to src, add 4 to dst unless fixed, and enter WR_GAP.
REQ-019 SHALL hold iomem_valid low for exactly one cycle in each GAP state; RD_GAP -> WR; WR_GAP -> RD if remaining > 0, else FIN.
REQ-020 SHALL, in FIN, pulse done for one cycle and return to IDLE.
REQ-021 SHALL wrap address increments modulo 2^32 with no error.
REQ-022 SHALL, with a zero-wait responder (ready one cycle after valid), take 6 cycles per word, with done at acceptance + 6*len + 1.
REQ-023 SHALL ignore iomem_ready when iomem_valid is low.
REQ-024 SHALL drive iomem_valid, iomem_wstrb, iomem_addr and iomem_wdata from registers only.

Reset
REQ-025 SHALL, while resetn is low at an edge, force IDLE; iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata, busy, done and err to 0; cmd_ready to 0 during reset and to 1 on the first cycle after release.
REQ-026 SHALL, on reset mid-transfer, abandon the transfer without done or err, and drop iomem_valid on that edge.

Configuration
REQ-027 SHALL, with IOMEM_DMA_TIMEOUT_EN defined, count consecutive cycles with iomem_valid high and iomem_ready low; when the count reaches TIMEOUT_CYCLES, drop valid, go to FIN, and pulse err together with done.
REQ-028 SHALL, without IOMEM_DMA_TIMEOUT_EN, wait indefinitely for ready and tie err to 0.

Structure
REQ-029 SHALL take the FSM state enum, the WSTRB_READ (4'h0) and WSTRB_WORD (4'hF) constants, and ADDR_STEP (4) from shared package iomem_pkg.
REQ-030 SHALL place the single-transaction valid/ready/timeout engine in sub-module iomem_master_port, instantiated once.

Verification
REQ-031 SHALL cover: src 0x1000, dst 0x2000, len 3, zero-wait responder -> reads 0x1000/0x1004/0x1008, writes 0x2000/0x2004/0x2008 with matching data, done at cycle 19.
REQ-032 SHALL cover: len 0 -> no iomem_valid, done 1 cycle after acceptance, err 0.
REQ-033 SHALL cover: responder with 3 wait states, dst_fixed 1, dst 0x3000, len 2 -> both writes to 0x3000, addr/wdata stable during wait.
REQ-034 SHALL cover: src 0xFFFFFFFC, len 2 -> second read at 0x00000000.
REQ-035 SHALL cover: resetn low during the second WR of len 4 -> iomem_valid 0 next cycle, no done, cmd_ready 1 after release.
REQ-036 SHALL cover: IOMEM_DMA_TIMEOUT_EN with TIMEOUT_CYCLES 8, responder never ready -> valid drops after 8 cycles, done and err pulse together.

Source files
------------

// File: rtl/iomem_pkg.sv
// Shared definitions for the iomem word-copy DMA: widths, FSM states, strobe
// constants, the single-transaction request payload and an address helper.
// No ports (package).
package iomem_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned STRB_W    = 4;
  localparam int unsigned ADDR_STEP = 4;

  localparam logic [STRB_W-1:0] WSTRB_READ = 4'h0;
  localparam logic [STRB_W-1:0] WSTRB_WORD = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_GAP,
    WR,
    WR_GAP,
    FIN
  } dma_state_t;

  // Payload loaded into the bus master when a transaction is launched.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } iomem_req_t;

  // Clear the byte-offset bits; the bus only ever sees word addresses.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/iomem_dma_if.sv
// iomem bus bundle (PicoRV32-style valid/ready memory port).
// Signals: valid, ready, wstrb[3:0] (0 = read), addr[31:0], wdata[31:0], rdata[31:0].
// Modports: master (initiator side), slave (responder side).
interface iomem_dma_if;
  import iomem_pkg::*;

  logic              valid;
  logic              ready;
  logic [STRB_W-1:0] wstrb;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output valid, wstrb, addr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  valid, wstrb, addr, wdata,
    output ready, rdata
  );

endinterface

// File: rtl/iomem_master_port.sv
// Single-transaction iomem initiator: launches one read or write on 'start',
// holds the registered request stable until ready, then drops valid.
// Optional stall watchdog compiled in with IOMEM_DMA_TIMEOUT_EN.
// Ports:
//   clk, resetn       clock, synchronous active-low reset
//   start             launch a transaction with payload 'req' (only while idle)
//   req               address / write data / strobe for the transaction
//   ack_c             combinational: handshake completes on this edge
//   timeout_c         combinational: stall limit reached on this edge
//   bus               iomem master modport (valid/wstrb/addr/wdata registered)
module iomem_master_port
  import iomem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  iomem_req_t   req,
  output logic         ack_c,
  output logic         timeout_c,
  iomem_dma_if.master  bus
);

  assign ack_c = bus.valid && bus.ready;

  // Request registers: loaded on launch, frozen until the handshake or timeout.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.valid <= 1'b0;
      bus.addr  <= '0;
      bus.wdata <= '0;
      bus.wstrb <= '0;
    end else if (start) begin
      bus.valid <= 1'b1;
      bus.addr  <= req.addr;
      bus.wdata <= req.wdata;
      bus.wstrb <= req.wstrb;
    end else if (ack_c || timeout_c) begin
      bus.valid <= 1'b0;
    end
  end

`ifdef IOMEM_DMA_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] stall_cnt;
  logic             stalled_c;

  assign stalled_c = bus.valid && !bus.ready;
  // The counter holds the number of stalled cycles already seen, so the
  // limit fires during the TIMEOUT_CYCLES-th consecutive stalled cycle.
  assign timeout_c = stalled_c && (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Consecutive-stall counter; any non-stalled cycle restarts it.
  always_ff @(posedge clk) begin
    if (!resetn || !stalled_c || timeout_c) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign timeout_c      = 1'b0;
`endif

endmodule

// File: rtl/iomem_dma.sv
// Word-copy DMA over the iomem bus: reads cmd_len words from cmd_src and
// writes each one to cmd_dst (incrementing, or fixed for a FIFO-style sink).
// Optional build macro: IOMEM_DMA_TIMEOUT_EN enables the per-transaction
// stall watchdog (abort with err); without it err is tied low.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   cmd_valid / cmd_ready       command handshake (ready only while idle)
//   cmd_src, cmd_dst            byte addresses, low two bits ignored
//   cmd_len, cmd_dst_fixed      word count; 1 = destination not incremented
//   busy                        high whenever a command is in progress
//   done, err                   one-cycle completion pulse; err marks a timeout
//   iomem                       iomem master modport
module iomem_dma
  import iomem_pkg::*;
#(
  parameter int unsigned LEN_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_dst_fixed,
  output logic              busy,
  output logic              done,
  output logic              err,
  iomem_dma_if.master       iomem
);

  dma_state_t        state;
  dma_state_t        next_state;

  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [LEN_W-1:0]  remain_q;
  logic              fixed_q;
  logic [DATA_W-1:0] rd_data_q;

  logic              accept_c;
  logic              start;
  iomem_req_t        req;
  logic              ack_c;
  logic              timeout_c;

  assign accept_c = cmd_valid && cmd_ready;

  iomem_master_port #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_port (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .req       (req),
    .ack_c     (ack_c),
    .timeout_c (timeout_c),
    .bus       (iomem)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and transaction launch; a launch is issued on every entry
  // into RD or WR so the port's registers are valid in the first bus cycle.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    req        = '{addr: src_q, wdata: rd_data_q, wstrb: WSTRB_READ};

    unique case (state)
      IDLE: begin
        if (accept_c) begin
          if (cmd_len == '0) begin
            next_state = FIN;
          end else begin
            next_state = RD;
            start      = 1'b1;
            req.addr   = word_addr(cmd_src);
          end
        end
      end
      RD: begin
        if (timeout_c) begin
          next_state = FIN;
        end else if (ack_c) begin
          next_state = RD_GAP;
        end
      end
      RD_GAP: begin
        next_state = WR;
        start      = 1'b1;
        req.addr   = dst_q;
        req.wstrb  = WSTRB_WORD;
      end
      WR: begin
        if (timeout_c) begin
          next_state = FIN;
        end else if (ack_c) begin
          next_state = WR_GAP;
        end
      end
      WR_GAP: begin
        if (remain_q != '0) begin
          next_state = RD;
          start      = 1'b1;
        end else begin
          next_state = FIN;
        end
      end
      FIN: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Command latch, read-data capture and per-word pointer advance.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      src_q     <= '0;
      dst_q     <= '0;
      remain_q  <= '0;
      fixed_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (state == IDLE && accept_c) begin
        src_q    <= word_addr(cmd_src);
        dst_q    <= word_addr(cmd_dst);
        remain_q <= cmd_len;
        fixed_q  <= cmd_dst_fixed;
      end
      if (state == RD && ack_c) begin
        rd_data_q <= iomem.rdata;
      end
      if (state == WR && ack_c) begin
        remain_q <= remain_q - LEN_W'(1);
        src_q    <= src_q + ADDR_W'(ADDR_STEP);
        if (!fixed_q) begin
          dst_q <= dst_q + ADDR_W'(ADDR_STEP);
        end
      end
    end
  end

  // Status outputs registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      cmd_ready <= (next_state == IDLE);
      busy      <= (next_state != IDLE);
      done      <= (next_state == FIN);
    end
  end

`ifdef IOMEM_DMA_TIMEOUT_EN
  // A timeout always routes to FIN, so err lands together with done.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err <= 1'b0;
    end else begin
      err <= timeout_c;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_iomem_dma.sv
// Self-checking bench for iomem_dma: directed vector table, hand-written
// reset/timeout sequences and randomized commands, all compared against a
// transaction-level model of the expected bus traffic and done timing.
module tb_iomem_dma;

  localparam int unsigned LEN_W = 16;
  localparam int unsigned TO    = 8;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [31:0]      cmd_src = '0;
  logic [31:0]      cmd_dst = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             cmd_dst_fixed = 1'b0;
  logic             busy;
  logic             done;
  logic             err;

  iomem_dma_if bus ();

  iomem_dma #(
    .LEN_W          (LEN_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_src       (cmd_src),
    .cmd_dst       (cmd_dst),
    .cmd_len       (cmd_len),
    .cmd_dst_fixed (cmd_dst_fixed),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .iomem         (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory contents seen by reads: a fixed scramble of the word address.
  logic [31:0] salt = 32'h5A17_C0DE;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  assign bus.rdata = mem_word(bus.addr);

  // Responder: 'waits' extra stall cycles before ready; negative = never ready.
  int waits = 0;
  int stall_s = 0;

  always @(posedge clk) begin
    if (!resetn) begin
      bus.ready <= 1'b0;
      stall_s   <= 0;
    end else if (bus.valid && !bus.ready) begin
      if (waits >= 0 && stall_s >= waits) begin
        bus.ready <= 1'b1;
        stall_s   <= 0;
      end else begin
        stall_s <= stall_s + 1;
      end
    end else begin
      bus.ready <= 1'b0;
      stall_s   <= 0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: logs completed transfers and counts events at mid-cycle.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } xfer_t;

  xfer_t       bus_q[$];
  int          valid_cycles = 0;
  int          done_cnt = 0;
  int          stab_bad = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;
  logic [3:0]  prev_strb = '0;

  always @(negedge clk) begin
    if (resetn) begin
      if (bus.valid) valid_cycles++;
      if (done) done_cnt++;
      if (prev_stall && bus.valid &&
          (bus.addr != prev_addr || bus.wdata != prev_wdata || bus.wstrb != prev_strb))
        stab_bad++;
      if (bus.valid && bus.ready)
        bus_q.push_back('{addr: bus.addr,
                          data: (bus.wstrb == 4'h0) ? bus.rdata : bus.wdata,
                          strb: bus.wstrb});
    end
    prev_stall = resetn && bus.valid && !bus.ready;
    prev_addr  = bus.addr;
    prev_wdata = bus.wdata;
    prev_strb  = bus.wstrb;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one command and compare traffic/timing with the transaction model.
  task automatic run_cmd(input string tag, input logic [31:0] src, input logic [31:0] dst,
                         input int len, input logic fixed, input int w,
                         input int exp_delta, input bit to_case);
    int          acc_k;
    int          base_n;
    int          base_v;
    int          base_stab;
    int          guard;
    int          nwords;
    logic [31:0] s;
    logic [31:0] d;
    logic [31:0] ra;
    logic [31:0] wa;
    xfer_t       e;

    waits     = w;
    base_n    = bus_q.size();
    base_v    = valid_cycles;
    base_stab = stab_bad;
    s         = src & ~32'd3;
    d         = dst & ~32'd3;

    @(negedge clk);
    cmd_valid     = 1'b1;
    cmd_src       = src;
    cmd_dst       = dst;
    cmd_len       = LEN_W'(len);
    cmd_dst_fixed = fixed;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("%s/cmd_ready", tag), 32'(cmd_ready), 32'd1);
    acc_k = cyc;

    // Inputs change after acceptance; the latched command must be used.
    @(negedge clk);
    cmd_valid     = 1'b0;
    cmd_src       = $urandom;
    cmd_dst       = $urandom;
    cmd_len       = LEN_W'($urandom);
    cmd_dst_fixed = ~fixed;
    check($sformatf("%s/busy_on", tag), 32'(busy), 32'd1);
    check($sformatf("%s/ready_off", tag), 32'(cmd_ready), 32'd0);

    guard = 0;
    while (!done && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("%s/done_seen", tag), 32'(done), 32'd1);
    check($sformatf("%s/done_cycle", tag), 32'(cyc - acc_k), 32'(exp_delta));
    check($sformatf("%s/err", tag), 32'(err), 32'(to_case));

    @(negedge clk);
    check($sformatf("%s/done_pulse", tag), 32'(done), 32'd0);
    check($sformatf("%s/busy_off", tag), 32'(busy), 32'd0);
    check($sformatf("%s/ready_back", tag), 32'(cmd_ready), 32'd1);

    nwords = to_case ? 0 : len;
    check($sformatf("%s/xfers", tag), 32'(bus_q.size() - base_n), 32'(2 * nwords));
    if (bus_q.size() - base_n == 2 * nwords) begin
      for (int i = 0; i < nwords; i++) begin
        ra = s + 32'(4 * i);
        wa = fixed ? d : d + 32'(4 * i);
        e = bus_q[base_n + 2 * i];
        check($sformatf("%s/rd%0d_addr", tag, i), e.addr, ra);
        check($sformatf("%s/rd%0d_strb", tag, i), 32'(e.strb), 32'h0);
        check($sformatf("%s/rd%0d_data", tag, i), e.data, mem_word(ra));
        e = bus_q[base_n + 2 * i + 1];
        check($sformatf("%s/wr%0d_addr", tag, i), e.addr, wa);
        check($sformatf("%s/wr%0d_strb", tag, i), 32'(e.strb), 32'hF);
        check($sformatf("%s/wr%0d_data", tag, i), e.data, mem_word(ra));
      end
    end
    check($sformatf("%s/stable", tag), 32'(stab_bad - base_stab), 32'd0);
    if (len == 0)
      check($sformatf("%s/no_valid", tag), 32'(valid_cycles - base_v), 32'd0);
    if (to_case)
      check($sformatf("%s/valid_len", tag), 32'(valid_cycles - base_v), 32'(TO));
    waits = 0;
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          len;
    logic        fixed;
    int          w;
    int          exp_delta;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int guard;
    int base_n;
    int base_done;
    int len;
    int w;

    // Directed table: expected done cycle from 6+2*waits cycles per word.
    vecs[0] = '{src: 32'h0000_1000, dst: 32'h0000_2000, len: 3, fixed: 1'b0, w: 0, exp_delta: 19};
    vecs[1] = '{src: 32'h0000_1000, dst: 32'h0000_2000, len: 0, fixed: 1'b0, w: 0, exp_delta: 1};
    vecs[2] = '{src: 32'h0000_5000, dst: 32'h0000_3000, len: 2, fixed: 1'b1, w: 3, exp_delta: 25};
    vecs[3] = '{src: 32'hFFFF_FFFC, dst: 32'h0000_8000, len: 2, fixed: 1'b0, w: 0, exp_delta: 13};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst/valid", 32'(bus.valid), 32'd0);
    check("rst/wstrb", 32'(bus.wstrb), 32'd0);
    check("rst/addr", bus.addr, 32'd0);
    check("rst/wdata", bus.wdata, 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/err", 32'(err), 32'd0);
    check("rst/cmd_ready", 32'(cmd_ready), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("rel/cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 4; i++)
      run_cmd($sformatf("vec%0d", i), vecs[i].src, vecs[i].dst, vecs[i].len,
              vecs[i].fixed, vecs[i].w, vecs[i].exp_delta, 1'b0);

    // Reset during the second write of a 4-word copy.
    waits     = 0;
    base_n    = bus_q.size();
    base_done = done_cnt;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_src = 32'h0000_4000; cmd_dst = 32'h0000_6000;
    cmd_len = LEN_W'(4); cmd_dst_fixed = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    guard = 0;
    while (!(bus.valid && bus.wstrb == 4'hF && !bus.ready && bus_q.size() - base_n == 3)
           && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("midrst/reach_wr2", 32'(guard < 200), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst/valid", 32'(bus.valid), 32'd0);
    check("midrst/busy", 32'(busy), 32'd0);
    check("midrst/done", 32'(done), 32'd0);
    check("midrst/cmd_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("midrst/ready_after", 32'(cmd_ready), 32'd1);
    repeat (10) @(negedge clk);
    check("midrst/no_done", 32'(done_cnt - base_done), 32'd0);
    check("midrst/xfers", 32'(bus_q.size() - base_n), 32'd3);
    check("midrst/idle_valid", 32'(bus.valid), 32'd0);

`ifdef IOMEM_DMA_TIMEOUT_EN
    // Responder never ready: valid held TO cycles, then done+err.
    run_cmd("timeout", 32'h0000_7000, 32'h0000_9000, 1, 1'b0, -1, TO + 1, 1'b1);
`endif

    // Randomized commands, unaligned addresses included.
    for (int n = 0; n < 20; n++) begin
      salt = $urandom;
      len  = int'($urandom_range(0, 5));
      w    = int'($urandom_range(0, 2));
      run_cmd($sformatf("rnd%0d", n), $urandom, $urandom, len, 1'($urandom_range(0, 1)),
              w, len * (6 + 2 * w) + 1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
